mant_align_unit: RTL and testbench

//  Consumes the exponent-swap result (compare flag, lesser/greater exponent) plus both mantissas.

---
 rtl/fp_align_pkg.sv | 26 ++
 rtl/mant_align_unit_sticky_shr.sv | 28 ++
 rtl/mant_align_unit.sv | 162 ++++++++++++++++
 tb/tb_mant_align_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared types and constants for the mantissa alignment unit.
// Build option: MANT_ALIGN_BARREL_EN selects a one-cycle barrel shifter
// instead of the iterative 1-bit/cycle shifter.
package fp_align_pkg;

  typedef enum logic [1:0] {
    ALIGN_IDLE  = 2'd0,
    ALIGN_SHIFT = 2'd1,
    ALIGN_DONE  = 2'd2
  } align_state_t;

  // Default aligned width: hidden bit + 23-bit fraction + guard/round/sticky.
  localparam int SIZE_MAN_DEF = 23;
  localparam int GRS_W        = 3;
  localparam int W            = SIZE_MAN_DEF + 1 + GRS_W;

  // Shifting past the full aligned width only feeds sticky, so cap the amount there.
  function automatic logic [31:0] clamp_shift(input logic [31:0] diff, input logic [31:0] lim);
    if (diff > lim) begin
      return lim;
    end else begin
      return diff;
    end
  endfunction

endpackage

// File: rtl/mant_align_unit_sticky_shr.sv
// Combinational right shifter with sticky collection, used by the
// single-cycle alignment build (MANT_ALIGN_BARREL_EN).
// Bit 0 of the result is the OR of every bit shifted out plus the bit
// that lands in position 0, matching the iterative shifter exactly.
`ifdef MANT_ALIGN_BARREL_EN
module align_sticky_shr #(
  parameter int W  = 27,
  parameter int SW = 5
) (
  input  logic [W-1:0]  i_value,
  input  logic [SW-1:0] i_shift,
  output logic [W-1:0]  o_value,
  output logic          o_sticky
);

  logic [W-1:0] w_lost_mask;
  logic [W-1:0] w_shifted;

  // Mask of bits that fall off the bottom, shift them and fold sticky into bit 0.
  always_comb begin
    w_lost_mask = ~({W{1'b1}} << i_shift);
    w_shifted   = i_value >> i_shift;
    o_sticky    = |(i_value & w_lost_mask);
    o_value     = {w_shifted[W-1:1], w_shifted[0] | o_sticky};
  end

endmodule
`endif

// File: rtl/mant_align_unit.sv
// Mantissa alignment stage for FP add/sub: selects greater/lesser mantissa
// from the exponent compare flag, left-justifies both into {man,G,R,S} and
// right-shifts the lesser one by the exponent difference with sticky.
// Build option: MANT_ALIGN_BARREL_EN -> shift done combinationally at capture
// (fixed 1-cycle latency); otherwise shifts 1 bit per cycle.
module mant_align_unit
  import fp_align_pkg::*;
#(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_compare,
  input  logic [SIZE_EXP-1:0]   i_exp_less,
  input  logic [SIZE_EXP-1:0]   i_exp_greater,
  input  logic [SIZE_MAN:0]     i_man_a,
  input  logic [SIZE_MAN:0]     i_man_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_EXP-1:0]   o_exp_result,
  output logic [SIZE_MAN+3:0]   o_man_greater,
  output logic [SIZE_MAN+3:0]   o_man_less_align,
  output logic                  o_swap
);

  localparam int AW = SIZE_MAN + 1 + GRS_W;
  localparam int CW = $clog2(AW + 1);

  align_state_t r_state;
  align_state_t w_state_next;

  logic [SIZE_EXP-1:0] r_exp;
  logic [AW-1:0]       r_man_greater;
  logic [AW-1:0]       r_man_less;
  logic                r_swap;
  logic [CW-1:0]       r_count;

  logic [SIZE_EXP-1:0] w_diff;
  logic [CW-1:0]       w_count;
  logic [AW-1:0]       w_greater_just;
  logic [AW-1:0]       w_less_just;
  logic [AW-1:0]       w_less_capture;

  // Operand selection, left-justification and clamped shift amount.
  always_comb begin
    w_diff  = i_exp_greater - i_exp_less;
    w_count = CW'(clamp_shift(32'(w_diff), 32'(AW)));
    if (i_compare) begin
      w_greater_just = {i_man_b, {GRS_W{1'b0}}};
      w_less_just    = {i_man_a, {GRS_W{1'b0}}};
    end else begin
      w_greater_just = {i_man_a, {GRS_W{1'b0}}};
      w_less_just    = {i_man_b, {GRS_W{1'b0}}};
    end
  end

`ifdef MANT_ALIGN_BARREL_EN
  logic w_sticky_unused;

  align_sticky_shr #(
    .W  (AW),
    .SW (CW)
  ) u_sticky_shr (
    .i_value  (w_less_just),
    .i_shift  (w_count),
    .o_value  (w_less_capture),
    .o_sticky (w_sticky_unused)
  );
`else
  assign w_less_capture = w_less_just;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ALIGN_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; a new operand is only taken in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ALIGN_IDLE: begin
        if (i_valid) begin
`ifdef MANT_ALIGN_BARREL_EN
          w_state_next = ALIGN_DONE;
`else
          w_state_next = (w_count == CW'(0)) ? ALIGN_DONE : ALIGN_SHIFT;
`endif
        end else begin
          w_state_next = ALIGN_IDLE;
        end
      end
      ALIGN_SHIFT: begin
        if (r_count <= CW'(1)) begin
          w_state_next = ALIGN_DONE;
        end else begin
          w_state_next = ALIGN_SHIFT;
        end
      end
      ALIGN_DONE: begin
        if (i_ready) begin
          w_state_next = ALIGN_IDLE;
        end else begin
          w_state_next = ALIGN_DONE;
        end
      end
      default: begin
        w_state_next = ALIGN_IDLE;
      end
    endcase
  end

  // Datapath: capture in IDLE, shift one bit per SHIFT cycle, hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exp         <= '0;
      r_man_greater <= '0;
      r_man_less    <= '0;
      r_swap        <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_state)
        ALIGN_IDLE: begin
          if (i_valid) begin
            r_exp         <= i_exp_greater;
            r_man_greater <= w_greater_just;
            r_man_less    <= w_less_capture;
            r_swap        <= i_compare;
`ifdef MANT_ALIGN_BARREL_EN
            r_count       <= '0;
`else
            r_count       <= w_count;
`endif
          end
        end
        ALIGN_SHIFT: begin
          // Bit 0 is sticky: it absorbs whatever falls out of position 1 and 0.
          r_man_less <= {1'b0, r_man_less[AW-1:2], r_man_less[1] | r_man_less[0]};
          r_count    <= r_count - CW'(1);
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_ready          = (r_state == ALIGN_IDLE);
  assign o_valid          = (r_state == ALIGN_DONE);
  assign o_exp_result     = r_exp;
  assign o_man_greater    = r_man_greater;
  assign o_man_less_align = r_man_less;
  assign o_swap           = r_swap;

endmodule

// File: tb/tb_mant_align_unit.sv
// Self-checking bench for mant_align_unit (SIZE_EXP=8, SIZE_MAN=23, W=27).
module tb_mant_align_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cmp;
  logic [7:0]  exp_less;
  logic [7:0]  exp_greater;
  logic [23:0] man_a;
  logic [23:0] man_b;
  logic        out_valid;
  logic        in_ready;
  logic [7:0]  exp_result;
  logic [26:0] man_greater;
  logic [26:0] man_less;
  logic        swap;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  exp_r;
    logic [26:0] g;
    logic [26:0] l;
    logic        sw;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mant_align_unit #(.SIZE_EXP(8), .SIZE_MAN(23)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (in_valid),
    .o_ready          (out_ready),
    .i_compare        (cmp),
    .i_exp_less       (exp_less),
    .i_exp_greater    (exp_greater),
    .i_man_a          (man_a),
    .i_man_b          (man_b),
    .o_valid          (out_valid),
    .i_ready          (in_ready),
    .o_exp_result     (exp_result),
    .o_man_greater    (man_greater),
    .o_man_less_align (man_less),
    .o_swap           (swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alignment: shift the justified lesser mantissa, sticky = OR of lost bits.
  task automatic push_expected(input logic c, input logic [7:0] eg, input logic [7:0] el,
                               input logic [23:0] ma, input logic [23:0] mb);
    exp_t        e;
    logic [7:0]  d;
    int          k;
    logic [23:0] gm;
    logic [23:0] lm;
    logic [63:0] lf;
    logic [63:0] mask;
    gm = c ? mb : ma;
    lm = c ? ma : mb;
    d  = eg - el;
    k  = int'(d);
    if (k > 27) k = 27;
    lf   = {37'd0, lm, 3'b000};
    mask = (64'd1 << k) - 64'd1;
    e.l  = 27'(lf >> k) | {26'd0, |(lf & mask)};
    e.g  = {gm, 3'b000};
    e.exp_r = eg;
    e.sw = c;
`ifdef MANT_ALIGN_BARREL_EN
    e.lat = 1;
`else
    e.lat = k + 1;
`endif
    sb_q.push_back(e);
  endtask

  // Drive one operation, compare against the scoreboard, optionally stall downstream.
  task automatic run_op(input logic c, input logic [7:0] eg, input logic [7:0] el,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input int hold, output logic [26:0] less_obs);
    exp_t e;
    int   lat;
    int   wt;
    push_expected(c, eg, el, ma, mb);
    @(negedge clk);
    in_ready    = (hold == 0);
    cmp         = c;
    exp_greater = eg;
    exp_less    = el;
    man_a       = ma;
    man_b       = mb;
    in_valid    = 1'b1;
    wt = 0;
    while (!out_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    n_checks++;
    if (out_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_wait: o_ready=%b required 1", out_ready);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (lat !== e.lat) begin
      n_errors++;
      $display("FAIL latency: got %0d required %0d", lat, e.lat);
    end
    n_checks++;
    if (man_less !== e.l || man_greater !== e.g || exp_result !== e.exp_r || swap !== e.sw) begin
      n_errors++;
      $display("FAIL result: less=%h greater=%h exp=%0d swap=%b required less=%h greater=%h exp=%0d swap=%b",
               man_less, man_greater, exp_result, swap, e.l, e.g, e.exp_r, e.sw);
    end
    n_checks++;
    if (out_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_in_done: o_ready=%b required 0", out_ready);
    end
    less_obs = man_less;
    for (int h = 0; h < hold; h++) begin
      in_valid    = 1'b1;
      cmp         = ~c;
      exp_greater = 8'd200;
      exp_less    = 8'd1;
      man_a       = 24'($urandom);
      man_b       = 24'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || man_less !== e.l || man_greater !== e.g ||
          exp_result !== e.exp_r || swap !== e.sw) begin
        n_errors++;
        $display("FAIL hold_stable: valid=%b less=%h greater=%h required valid=1 less=%h greater=%h",
                 out_valid, man_less, man_greater, e.l, e.g);
      end
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL release: ready=%b valid=%b required ready=1 valid=0", out_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || man_less !== 27'd0 ||
        man_greater !== 27'd0 || exp_result !== 8'd0 || swap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b valid=%b less=%h greater=%h exp=%0d swap=%b required 1 0 0 0 0 0",
               out_ready, out_valid, man_less, man_greater, exp_result, swap);
    end
  endtask

  // Compare flag 0 selects operand a as the greater mantissa.
  task automatic test_equal_exp();
    logic [26:0] l;
    run_op(1'b0, 8'd127, 8'd127, 24'h800000, 24'hC00000, 0, l);
    n_checks++;
    if (l !== 27'h6000000) begin
      n_errors++;
      $display("FAIL equal_exp_less: got %h required %h", l, 27'h6000000);
    end
  endtask

  task automatic test_diff2();
    logic [26:0] l;
    run_op(1'b0, 8'd130, 8'd128, 24'hC00000, 24'h800000, 0, l);
    n_checks++;
    if (l !== 27'h1000000) begin
      n_errors++;
      $display("FAIL diff2_less: got %h required %h", l, 27'h1000000);
    end
  endtask

  task automatic test_saturate();
    logic [26:0] l;
    run_op(1'b1, 8'd157, 8'd127, 24'h800001, 24'hFFFFFF, 0, l);
    n_checks++;
    if (l !== 27'h0000001) begin
      n_errors++;
      $display("FAIL saturate_less: got %h required %h", l, 27'h0000001);
    end
    run_op(1'b0, 8'd255, 8'd0, 24'hABCDEF, 24'h000000, 0, l);
    n_checks++;
    if (l !== 27'h0000000) begin
      n_errors++;
      $display("FAIL saturate_zero: got %h required 0", l);
    end
  endtask

  task automatic test_grs();
    logic [26:0] l;
    run_op(1'b1, 8'd10, 8'd8, 24'h800003, 24'h900000, 0, l);
    n_checks++;
    if (l !== 27'h1000006) begin
      n_errors++;
      $display("FAIL grs_diff2: got %h required %h", l, 27'h1000006);
    end
    run_op(1'b1, 8'd11, 8'd8, 24'h800003, 24'h900000, 0, l);
    n_checks++;
    if (l !== 27'h0800003) begin
      n_errors++;
      $display("FAIL grs_diff3: got %h required %h", l, 27'h0800003);
    end
  endtask

  task automatic test_backpressure();
    logic [26:0] l;
    run_op(1'b0, 8'd140, 8'd133, 24'hF0F0F1, 24'h812345, 5, l);
  endtask

  task automatic test_reset_mid();
    logic [26:0] l;
    exp_t        e;
    push_expected(1'b1, 8'd150, 8'd130, 24'h8ABCDE, 24'hC12345);
    e = sb_q.pop_front();
    @(negedge clk);
    in_ready    = 1'b0;
    cmp         = 1'b1;
    exp_greater = 8'd150;
    exp_less    = 8'd130;
    man_a       = 24'h8ABCDE;
    man_b       = 24'hC12345;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
`ifdef MANT_ALIGN_BARREL_EN
    if (out_valid !== 1'b1 || man_less !== e.l) begin
`else
    if (out_valid !== 1'b0 || out_ready !== 1'b0) begin
`endif
      n_errors++;
      $display("FAIL mid_op_state: valid=%b ready=%b less=%h", out_valid, out_ready, man_less);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || man_less !== 27'd0 ||
        man_greater !== 27'd0 || exp_result !== 8'd0 || swap !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: ready=%b valid=%b less=%h greater=%h exp=%0d swap=%b required 1 0 0 0 0 0",
               out_ready, out_valid, man_less, man_greater, exp_result, swap);
    end
    @(negedge clk);
    rst = 1'b0;
    in_ready = 1'b1;
    run_op(1'b0, 8'd100, 8'd95, 24'hFFFFFF, 24'hA5A5A5, 0, l);
  endtask

  task automatic test_back_to_back();
    logic [26:0] l;
    logic [7:0]  eg;
    logic [7:0]  el;
    for (int i = 0; i < 8; i++) begin
      eg = 8'($urandom_range(255, 0));
      el = eg - 8'($urandom_range(int'(eg) < 40 ? int'(eg) : 40, 0));
      run_op(1'($urandom), eg, el, {1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, i % 2, l);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_ready    = 1'b1;
    cmp         = 1'b0;
    exp_less    = 8'd0;
    exp_greater = 8'd0;
    man_a       = 24'd0;
    man_b       = 24'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_equal_exp();
    test_diff2();
    test_saturate();
    test_grs();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
